// File: rtl/nn_fp_pkg.sv
// ---------------------------------------------------------------------------
// nn_fp_pkg
// Shared floating-point helpers for the dot-product result path.
//   - Exception flag bit positions and the exc_t flag vector type.
//   - is_nan  : NaN detection for a format of exp_width/mant_width.
//   - fp_relu : ReLU on a raw floating-point word (negatives, -0 and -inf
//               become +0; NaNs pass through untouched).
// Words are carried in a FP_MAX_W container so one function serves any
// format up to 64 bits. The layout is {sign, exponent, fraction}, where
// mant_width counts the sign bit plus the stored fraction bits, so the
// fraction field is mant_width-1 bits wide.
// ---------------------------------------------------------------------------
package nn_fp_pkg;

    localparam int EXC_W         = 5;
    localparam int EXC_INVALID   = 4;
    localparam int EXC_DIVZERO   = 3;
    localparam int EXC_OVERFLOW  = 2;
    localparam int EXC_UNDERFLOW = 1;
    localparam int EXC_INEXACT   = 0;

    localparam int FP_MAX_W = 64;

    typedef logic [EXC_W-1:0]    exc_t;
    typedef logic [FP_MAX_W-1:0] fp_word_t;

    // NaN: exponent all ones and a non-zero fraction.
    function automatic logic is_nan(input fp_word_t x,
                                    input int exp_width,
                                    input int mant_width);
        fp_word_t exp_mask;
        fp_word_t frac_mask;
        fp_word_t exp_field;
        fp_word_t frac_field;
        exp_mask   = (fp_word_t'(1) << exp_width) - fp_word_t'(1);
        frac_mask  = (fp_word_t'(1) << (mant_width - 1)) - fp_word_t'(1);
        exp_field  = (x >> (mant_width - 1)) & exp_mask;
        frac_field = x & frac_mask;
        return (exp_field == exp_mask) && (frac_field != '0);
    endfunction

    // Any value with the sign set that is not a NaN collapses to +0 when the
    // activation is enabled. A NaN keeps its sign so the payload survives.
    function automatic fp_word_t fp_relu(input fp_word_t x,
                                         input logic act_en,
                                         input int exp_width,
                                         input int mant_width);
        fp_word_t sign_bit;
        sign_bit = (x >> (exp_width + mant_width - 1)) & fp_word_t'(1);
        if (act_en && (sign_bit != '0) && !is_nan(x, exp_width, mant_width)) begin
            return '0;
        end
        return x;
    endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// ---------------------------------------------------------------------------
// fp_result_fifo
// Generic first-word-fall-through FIFO with an occupancy output.
//   clk, rst_n            : clock, asynchronous active-low reset
//   wr_valid / wr_ready   : write handshake (wr_ready = !full)
//   wr_data               : entry to store
//   rd_valid / rd_ready   : read handshake (rd_valid = !empty)
//   rd_data               : head entry, forced to 0 while empty
//   level                 : number of occupied entries
// DEPTH must be a power of two (>= 2) so the pointers wrap on their own;
// level is one bit wider than the pointers and tells full from empty.
// wr_ready depends only on the stored level, never on rd_ready, so a full
// FIFO refuses a write even in a cycle where it is also being read.
// ---------------------------------------------------------------------------
module fp_result_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0] level
);

    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [LVL_W-1:0] level_reg;
    logic [LVL_W-1:0] level_next;

    logic full;
    logic empty;
    logic wr_en;
    logic rd_en;

    assign full     = (level_reg == FULL_LEVEL);
    assign empty    = (level_reg == '0);
    assign wr_ready = !full;
    assign rd_valid = !empty;
    assign wr_en    = wr_valid && !full;
    assign rd_en    = rd_ready && !empty;
    assign level    = level_reg;

    // Fall-through read: the head entry is visible without a read strobe.
    assign rd_data  = empty ? '0 : mem[rd_ptr_reg];

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        if (wr_en) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
        end
    end

    // Storage is deliberately left without reset; the pointers define what
    // is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

endmodule

// File: rtl/relu_result_buffer.sv
// ---------------------------------------------------------------------------
// relu_result_buffer
// Output stage of the floating-point dot-product unit: optional ReLU on each
// result, FWFT buffering toward the next layer, sticky exception flags and a
// delivered-result counter.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   act_en                     : 1 = ReLU, 0 = identity (taken with the push)
//   in_valid/in_ready          : upstream handshake, in_data + in_exc
//   out_valid/out_ready        : downstream handshake, out_data + out_exc
//   level                      : occupied FIFO entries
//   sticky_exc / clr_sticky    : OR of accepted flags, synchronous clear
//   result_count               : completed output handshakes (wrapping)
// ---------------------------------------------------------------------------
module relu_result_buffer
    import nn_fp_pkg::*;
#(
    parameter int exp_width  = 8,
    parameter int mant_width = 24,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 16,
    localparam int DATA_W    = exp_width + mant_width,
    localparam int LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              act_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [4:0]        in_exc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_exc,
    output logic [LVL_W-1:0]  level,
    output logic [4:0]        sticky_exc,
    input  logic              clr_sticky,
    output logic [CNT_W-1:0]  result_count
);

    localparam int ENTRY_W = DATA_W + EXC_W;

    fp_word_t          relu_wide;
    logic [DATA_W-1:0] act_data;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;

    logic push;
    logic pop;

    exc_t             sticky_reg;
    exc_t             sticky_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // Activation happens before storage so the FIFO holds final values.
    always_comb begin
        relu_wide = fp_relu(FP_MAX_W'(in_data), act_en, exp_width, mant_width);
    end

    assign act_data = relu_wide[DATA_W-1:0];

    generate
        if (DATA_W < FP_MAX_W) begin : g_container_pad
            logic unused_hi;
            assign unused_hi = ^relu_wide[FP_MAX_W-1:DATA_W];
        end
    endgenerate

    assign wr_entry = {in_exc, act_data};

    fp_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (in_valid),
        .wr_ready (in_ready),
        .wr_data  (wr_entry),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_data  (head_entry),
        .level    (level)
    );

    assign out_data = head_entry[DATA_W-1:0];
    assign out_exc  = head_entry[ENTRY_W-1:DATA_W];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Clear first, then OR in the new flags, so a push in the clear cycle
    // is not lost.
    always_comb begin
        sticky_next = (clr_sticky ? '0 : sticky_reg) | (push ? in_exc : '0);
        count_next  = pop ? count_reg + CNT_W'(1) : count_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_reg <= '0;
            count_reg  <= '0;
        end else begin
            sticky_reg <= sticky_next;
            count_reg  <= count_next;
        end
    end

    assign sticky_exc   = sticky_reg;
    assign result_count = count_reg;

endmodule

// File: doc/relu_result_buffer.md
Name: relu_result_buffer

Overview:
- Downstream stage of the 1x2·2x1 floating-point dot-product unit. Captures each dot-product result and its exception flags.
- Optionally applies ReLU to the result, then buffers it in a small FIFO with first-word-fall-through.
- Presents results to the next layer's operand loader over a valid/ready handshake.
- Also keeps sticky exception flags and a count of delivered results.

Parameters:
- exp_width, 8, exponent field width.
- mant_width, 24, mantissa field width; data_width = exp_width + mant_width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of result_count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- act_en  input  1  1 = ReLU, 0 = identity; sampled at the handshake (in_valid & in_ready).
- in_valid  input  1  upstream result valid.
- in_ready  output  1  buffer can accept; equals !full.
- in_data  input  data_width  dot-product result (c1).
- in_exc  input  5  exception flags accompanying in_data.
- out_valid  output  1  head entry valid; equals !empty.
- out_ready  input  1  downstream accepts the head entry.
- out_data  output  data_width  head entry data.
- out_exc  output  5  head entry flags.
- level  output  $clog2(DEPTH)+1  current number of occupied entries.
- sticky_exc  output  5  OR of all flags accepted since reset or the last clear.
- clr_sticky  input  1  synchronous clear of sticky_exc.
- result_count  output  CNT_W  number of completed output handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, rst_n low) forces: pointers = 0, level = 0, out_valid = 0, in_ready = 1, sticky_exc = 0, result_count = 0.
  - out_data and out_exc read 0 while the FIFO is empty; the storage array is not reset.
- Reset asserted mid-operation discards all entries immediately. No handshake completes in that cycle.
- Push occurs on in_valid & in_ready; pop occurs on out_valid & out_ready.
- Push and pop in the same cycle: level unchanged, both pointers advance.
- Full: in_ready = 0, so no push, even if a pop occurs in the same cycle. There is no combinational ready path from out_ready.
- Empty: out_valid = 0, and out_ready is ignored.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level distinguishes full from empty.
- Latency: data pushed at edge N appears on out_data with out_valid = 1 after edge N when the FIFO was empty (one cycle). Otherwise it appears in FIFO order.
- out_data and out_exc are driven from the head entry (first-word-fall-through). They stay stable while out_valid & !out_ready.
- Activation is applied before storage, in a combinational function. s = sign, e = exponent, m = mantissa.
  - act_en = 0: data stored unchanged.
  - NaN (e all ones, m != 0): stored unchanged, sign included.
  - s = 1 and not NaN (negative values, -0, -inf): stored as all-zeros (+0).
  - Otherwise: stored unchanged.
- Flags are stored unchanged regardless of activation.
- Exception bit order, fixed in the package: [4] invalid, [3] divide-by-zero, [2] overflow, [1] underflow, [0] inexact.
- sticky_exc update each cycle: (clr_sticky ? 0 : sticky_exc) | (push ? in_exc : 0).
  - A push in the same cycle as clr_sticky therefore survives the clear.
- result_count increments by 1 on each pop and wraps from all-ones to 0.

Decomposition:
- Package nn_fp_pkg holds:
  - exception bit-index constants (EXC_INVALID = 4 … EXC_INEXACT = 0);
  - the exc_t typedef (logic [4:0]);
  - a fp_relu function parameterised by exp_width and mant_width;
  - an is_nan helper.
- One sub-module is natural: fp_result_fifo, a generic FWFT FIFO that takes width and depth and provides level.
  - The top level adds activation, sticky flags and the counter around it.

Test Plan:
- After reset, drive in_data = 32'h40A00000 (5.0), in_exc = 0, act_en = 1 for one cycle -> out_valid = 1 next cycle with out_data = 40A00000; pop with out_ready = 1 -> result_count = 1, level = 0.
- Drive C0A00000 (-5.0) with act_en = 1, then 80000000 (-0), then FF800000 (-inf) -> each output is 00000000. The same C0A00000 with act_en = 0 -> C0A00000.
- Drive FFC00000 (NaN) with in_exc = 5'b10000 -> out_data = FFC00000, out_exc = 10000, sticky_exc = 10000. Then assert clr_sticky together with a push carrying in_exc = 00001 -> sticky_exc = 00001.
- Hold out_ready = 0 and push 5 values -> in_ready drops after 4, level = 4, the 5th value is held upstream. Then out_ready = 1 with in_valid = 1 -> 4 values pop in order with no reorder, and the 5th is accepted once level < 4.
- Keep the FIFO at level = 2 with continuous push and pop -> level stays at 2, and the outputs are in order across pointer wrap-around.
- Assert rst_n low asynchronously mid-burst with level = 3 -> out_valid = 0, level = 0, result_count = 0 immediately, before the next clock edge.
- Force result_count to FFFF and complete one pop -> result_count = 0000.
